// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce
//   Synchronizes and debounces raw board switch/button pins on the core clock
//   and produces one-cycle rise/fall event pulses per bit.
//
// Ports:
//   clk_i        - core clock
//   arst_i       - asynchronous active-high reset
//   raw_i        - asynchronous pin levels [WIDTH]
//   stable_o     - debounced level [WIDTH]
//   rise_o       - one-cycle pulse when stable_o[i] goes 0->1 [WIDTH]
//   fall_o       - one-cycle pulse when stable_o[i] goes 1->0 [WIDTH]
//   any_change_o - OR of rise_o | fall_o, registered alongside the pulses
module gpio_in_debounce #(
  parameter int unsigned      WIDTH           = 12,
  parameter int unsigned      SYNC_STAGES     = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 250000,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             any_change_o
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // sync_q[0] samples the pin; sync_q[SYNC_STAGES-1] is the usable level.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  sync;
  logic [CNT_W-1:0]                  cnt_q [WIDTH];
  logic [CNT_W-1:0]                  cnt_d [WIDTH];
  logic [WIDTH-1:0]                  stable_q, stable_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic                              any_q, any_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      // Any agreement restarts the count, so short glitches never accumulate.
      cnt_d[i] = '0;
      if (sync[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync[i];
          rise_d[i]   = sync[i];
          fall_d[i]   = ~sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    any_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q   <= {SYNC_STAGES{RESET_VAL}};
      stable_q <= RESET_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
      any_q    <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      any_q    <= any_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign stable_o     = stable_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign any_change_o = any_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// tb_gpio_in_debounce
//   Self-checking bench for gpio_in_debounce with WIDTH=4, SYNC_STAGES=2,
//   DEBOUNCE_CYCLES=4, RESET_VAL=0. The reference model accepts a new level
//   when the synchronized input has differed from the accepted level over the
//   whole window of the last DEBOUNCE_CYCLES edges since the previous
//   acceptance or reset.
module tb_gpio_in_debounce;

  localparam int unsigned W  = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;
  localparam logic [W-1:0] RV = '0;

  logic         clk_i;
  logic         arst_i;
  logic [W-1:0] raw_i;
  logic [W-1:0] stable_o, rise_o, fall_o;
  logic         any_change_o;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           k;
  logic [W-1:0] raw_hist[$];
  int           last_acc[W];
  logic [W-1:0] exp_stable, exp_rise, exp_fall;
  logic         exp_any;

  gpio_in_debounce #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC),
    .RESET_VAL(RV)
  ) dut (
    .clk_i(clk_i),
    .arst_i(arst_i),
    .raw_i(raw_i),
    .stable_o(stable_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .any_change_o(any_change_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    k = 0;
    raw_hist.delete();
    for (int b = 0; b < W; b++) last_acc[b] = 0;
    exp_stable = RV;
    exp_rise   = '0;
    exp_fall   = '0;
    exp_any    = 1'b0;
  endtask

  // Synchronized level as seen before edge j (j counted from 1 after reset).
  function automatic logic [W-1:0] sync_at(int j);
    int m;
    m = j - int'(SS);
    if (m >= 1) return raw_hist[m-1];
    return RV;
  endfunction

  task automatic model_edge(logic [W-1:0] raw_now);
    bit ok;
    k++;
    raw_hist.push_back(raw_now);
    exp_rise = '0;
    exp_fall = '0;
    for (int b = 0; b < W; b++) begin
      ok = 1'b1;
      for (int j = k - int'(DC) + 1; j <= k; j++) begin
        if (j < 1 || j <= last_acc[b]) ok = 1'b0;
        else begin
          logic [W-1:0] s;
          s = sync_at(j);
          if (s[b] == exp_stable[b]) ok = 1'b0;
        end
      end
      if (ok) begin
        exp_stable[b] = ~exp_stable[b];
        exp_rise[b]   = exp_stable[b];
        exp_fall[b]   = ~exp_stable[b];
        last_acc[b]   = k;
      end
    end
    exp_any = |(exp_rise | exp_fall);
  endtask

  // Drive raw_i (we are always 1 time unit past a rising edge), advance one
  // edge, update the model and land 1 unit after the edge for sampling.
  task automatic step(logic [W-1:0] v);
    raw_i = v;
    @(posedge clk_i);
    if (!arst_i) model_edge(v);
    #1;
  endtask

  task automatic test_reset();
    raw_i  = 4'hF;
    arst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({stable_o, rise_o, fall_o, any_change_o} !== 13'h0) begin
      errors++;
      $display("FAIL reset_hold: got stable=%h rise=%h fall=%h any=%b, want all 0",
               stable_o, rise_o, fall_o, any_change_o);
    end
    model_reset();
    arst_i = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step(4'hF);
      checks++;
      if ({stable_o, rise_o, fall_o, any_change_o} !== {exp_stable, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL reset_release edge %0d: got s=%h r=%h f=%h a=%b want s=%h r=%h f=%h a=%b",
                 e, stable_o, rise_o, fall_o, any_change_o, exp_stable, exp_rise, exp_fall, exp_any);
      end
      if (e == 5) begin
        checks++;
        if (stable_o !== 4'h0) begin
          errors++;
          $display("FAIL reset_early edge 5: got stable=%h want 0", stable_o);
        end
      end
      if (e == 6) begin
        checks++;
        if (stable_o !== 4'hF || rise_o !== 4'hF || any_change_o !== 1'b1) begin
          errors++;
          $display("FAIL reset_accept edge 6: got s=%h r=%h a=%b want s=f r=f a=1",
                   stable_o, rise_o, any_change_o);
        end
      end
    end
  endtask

  task automatic test_clean_edge();
    int first_rise, n_rise, first_fall, n_fall;
    for (int e = 0; e < 8; e++) step(4'h0);
    first_rise = -1; n_rise = 0;
    for (int e = 1; e <= 9; e++) begin
      step(4'h1);
      if (rise_o[0]) begin n_rise++; if (first_rise < 0) first_rise = e; end
      checks++;
      if ({stable_o, rise_o, fall_o, any_change_o} !== {exp_stable, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL clean_rise edge %0d: got s=%h r=%h f=%h a=%b want s=%h r=%h f=%h a=%b",
                 e, stable_o, rise_o, fall_o, any_change_o, exp_stable, exp_rise, exp_fall, exp_any);
      end
    end
    checks++;
    if (first_rise != 6 || n_rise != 1) begin
      errors++;
      $display("FAIL clean_rise_latency: got edge %0d count %0d, want edge 6 count 1", first_rise, n_rise);
    end
    first_fall = -1; n_fall = 0;
    for (int e = 1; e <= 9; e++) begin
      step(4'h0);
      if (fall_o[0]) begin n_fall++; if (first_fall < 0) first_fall = e; end
      checks++;
      if ({stable_o, rise_o, fall_o, any_change_o} !== {exp_stable, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL clean_fall edge %0d: got s=%h r=%h f=%h a=%b want s=%h r=%h f=%h a=%b",
                 e, stable_o, rise_o, fall_o, any_change_o, exp_stable, exp_rise, exp_fall, exp_any);
      end
    end
    checks++;
    if (first_fall != 6 || n_fall != 1) begin
      errors++;
      $display("FAIL clean_fall_latency: got edge %0d count %0d, want edge 6 count 1", first_fall, n_fall);
    end
  endtask

  task automatic test_glitch();
    logic [W-1:0] pat[$];
    int npulse, acc_edge;
    pat = '{4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    npulse = 0;
    foreach (pat[i]) begin
      step(pat[i]);
      if (any_change_o || rise_o != 0 || fall_o != 0) npulse++;
      checks++;
      if ({stable_o, rise_o, fall_o, any_change_o} !== {exp_stable, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL glitch_short idx %0d: got s=%h r=%h f=%h a=%b want s=%h r=%h f=%h a=%b",
                 i, stable_o, rise_o, fall_o, any_change_o, exp_stable, exp_rise, exp_fall, exp_any);
      end
    end
    checks++;
    if (npulse != 0 || stable_o !== 4'h0) begin
      errors++;
      $display("FAIL glitch_reject: got pulses=%0d stable=%h, want 0 and 0", npulse, stable_o);
    end
    pat = '{4'h2, 4'h0, 4'h2, 4'h0};
    foreach (pat[i]) begin
      step(pat[i]);
      checks++;
      if ({stable_o, rise_o, fall_o, any_change_o} !== {exp_stable, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL glitch_bounce idx %0d: got s=%h r=%h f=%h a=%b want s=%h r=%h f=%h a=%b",
                 i, stable_o, rise_o, fall_o, any_change_o, exp_stable, exp_rise, exp_fall, exp_any);
      end
    end
    acc_edge = -1;
    for (int e = 1; e <= 9; e++) begin
      step(4'h2);
      if (rise_o[1] && acc_edge < 0) acc_edge = e;
      checks++;
      if ({stable_o, rise_o, fall_o, any_change_o} !== {exp_stable, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL glitch_hold edge %0d: got s=%h r=%h f=%h a=%b want s=%h r=%h f=%h a=%b",
                 e, stable_o, rise_o, fall_o, any_change_o, exp_stable, exp_rise, exp_fall, exp_any);
      end
    end
    checks++;
    if (acc_edge != 6) begin
      errors++;
      $display("FAIL glitch_accept_latency: got edge %0d, want 6", acc_edge);
    end
    for (int e = 0; e < 8; e++) step(4'h0);
  endtask

  task automatic test_independent_bits();
    int e2, e3, both;
    both = 0;
    for (int e = 1; e <= 8; e++) begin
      step(4'hC);
      if (rise_o === 4'hC) both++;
      checks++;
      if ({stable_o, rise_o, fall_o, any_change_o} !== {exp_stable, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL indep_same edge %0d: got s=%h r=%h f=%h a=%b want s=%h r=%h f=%h a=%b",
                 e, stable_o, rise_o, fall_o, any_change_o, exp_stable, exp_rise, exp_fall, exp_any);
      end
    end
    checks++;
    if (both != 1) begin
      errors++;
      $display("FAIL indep_simultaneous: got %0d cycles with rise=1100, want 1", both);
    end
    for (int e = 0; e < 8; e++) step(4'h0);
    e2 = -1; e3 = -1;
    for (int e = 1; e <= 11; e++) begin
      step(e <= 2 ? 4'h4 : 4'hC);
      if (rise_o === 4'h4) e2 = e;
      if (rise_o === 4'h8) e3 = e;
      checks++;
      if ({stable_o, rise_o, fall_o, any_change_o} !== {exp_stable, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL indep_stagger edge %0d: got s=%h r=%h f=%h a=%b want s=%h r=%h f=%h a=%b",
                 e, stable_o, rise_o, fall_o, any_change_o, exp_stable, exp_rise, exp_fall, exp_any);
      end
    end
    checks++;
    if (e2 != 6 || e3 != 8) begin
      errors++;
      $display("FAIL indep_stagger_timing: got bit2 edge %0d bit3 edge %0d, want 6 and 8", e2, e3);
    end
  endtask

  task automatic test_reset_mid();
    // stable_o is 1100 from the previous scenario.
    for (int e = 1; e <= 4; e++) step(4'hD);
    arst_i = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({stable_o, rise_o, fall_o, any_change_o} !== 13'h0) begin
      errors++;
      $display("FAIL reset_mid_async: got s=%h r=%h f=%h a=%b, want all 0",
               stable_o, rise_o, fall_o, any_change_o);
    end
    step(4'hD);
    step(4'hD);
    checks++;
    if ({stable_o, rise_o, fall_o, any_change_o} !== 13'h0) begin
      errors++;
      $display("FAIL reset_mid_hold: got s=%h r=%h f=%h a=%b, want all 0",
               stable_o, rise_o, fall_o, any_change_o);
    end
    arst_i = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step(4'hD);
      checks++;
      if ({stable_o, rise_o, fall_o, any_change_o} !== {exp_stable, exp_rise, exp_fall, exp_any}) begin
        errors++;
        $display("FAIL reset_mid_release edge %0d: got s=%h r=%h f=%h a=%b want s=%h r=%h f=%h a=%b",
                 e, stable_o, rise_o, fall_o, any_change_o, exp_stable, exp_rise, exp_fall, exp_any);
      end
      if (e == 5 && stable_o !== 4'h0) begin
        errors++;
        $display("FAIL reset_mid_early edge 5: got stable=%h want 0", stable_o);
      end
      if (e == 6 && (stable_o !== 4'hD || rise_o !== 4'hD)) begin
        errors++;
        $display("FAIL reset_mid_accept edge 6: got s=%h r=%h want s=d r=d", stable_o, rise_o);
      end
    end
    checks += 2;
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    v = raw_i;
    for (int e = 0; e < 600; e++) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 4) == 0) v[b] = ~v[b];
      end
      if ($urandom_range(0, 9) == 0) begin
        for (int h = 0; h < int'($urandom_range(3, 8)); h++) begin
          step(v);
          checks++;
          if ({stable_o, rise_o, fall_o, any_change_o} !== {exp_stable, exp_rise, exp_fall, exp_any}) begin
            errors++;
            $display("FAIL random_hold edge %0d: got s=%h r=%h f=%h a=%b want s=%h r=%h f=%h a=%b",
                     k, stable_o, rise_o, fall_o, any_change_o, exp_stable, exp_rise, exp_fall, exp_any);
          end
        end
      end else begin
        step(v);
        checks++;
        if ({stable_o, rise_o, fall_o, any_change_o} !== {exp_stable, exp_rise, exp_fall, exp_any}) begin
          errors++;
          $display("FAIL random edge %0d: got s=%h r=%h f=%h a=%b want s=%h r=%h f=%h a=%b",
                   k, stable_o, rise_o, fall_o, any_change_o, exp_stable, exp_rise, exp_fall, exp_any);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_edge();
    test_glitch();
    test_independent_bits();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_in_debounce.md
# gpio_in_debounce

Board-input conditioning stage for the riscv_udm_memsplit boards. It synchronizes and debounces raw switch and button pins before they reach the core's `gpio_bi` and reset logic, and produces one-cycle rise/fall event pulses per bit. It sits directly upstream of the SoC's GPIO input port in each board top, on the core clock (the DCM-divided clock).

## Interface

Parameters:
- `WIDTH`, 12: number of conditioned inputs (on NEXYS2: 8 switches plus 4 buttons).
- `SYNC_STAGES`, 2: synchronizer flop depth; legal range 2..4.
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles needed to accept a new level; must be at least 1. Counter width is clog2(DEBOUNCE_CYCLES+1).
- `RESET_VAL`, {WIDTH{1'b0}}: reset value of the synchronizer flops and of `stable_o`.

Ports:
- `clk_i`, input, 1: core clock.
- `arst_i`, input, 1: reset, asynchronous, active-high.
- `raw_i`, input, WIDTH: asynchronous pin levels.
- `stable_o`, output, WIDTH: debounced level; feeds `gpio_bi`.
- `rise_o`, output, WIDTH: one-cycle pulse when `stable_o[i]` goes 0→1.
- `fall_o`, output, WIDTH: one-cycle pulse when `stable_o[i]` goes 1→0.
- `any_change_o`, output, 1: OR of `rise_o | fall_o`, registered in the same cycle as the pulses.

## Operation

- Per bit i, `raw_i[i]` passes through a chain of `SYNC_STAGES` flops. The last flop is `sync[i]`.
- Each bit has an independent counter `cnt[i]` and register `stable[i]`. On every clock edge:
  - If `sync[i] == stable[i]`: `cnt[i] <= 0`. The pulse for that bit is 0.
  - If `sync[i] != stable[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `stable[i] <= sync[i]`, `cnt[i] <= 0`, and the matching `rise_o[i]` or `fall_o[i]` is set to 1.
  - Otherwise: `cnt[i] <= cnt[i]+1`. The pulses are 0.
- A disagreement that lasts fewer than `DEBOUNCE_CYCLES` consecutive cycles has no effect. The counter restarts from 0 on the next agreement, so glitches never accumulate.
- `rise_o`, `fall_o` and `any_change_o` are registers. Each is high for exactly one cycle per accepted transition. `rise_o[i]` and `fall_o[i]` are never both high.
- Bits are fully independent. Simultaneous transitions on several bits produce simultaneous pulses.
- The counter never exceeds `DEBOUNCE_CYCLES-1`; there is no wrap.
- With `DEBOUNCE_CYCLES == 1`, a level change is accepted on the first edge it appears on `sync`.

## Timing

- Reset (`arst_i` high, at any time, including mid-count):
  - Sync flops are forced to `RESET_VAL` immediately.
  - `stable_o` is forced to `RESET_VAL` immediately.
  - `cnt` is forced to 0.
  - `rise_o`, `fall_o` and `any_change_o` are forced to 0.
  - No pulse is produced on reset entry or exit.
- After reset release, if `raw_i` differs from `RESET_VAL`, the normal debounce sequence applies. The resulting first transition does produce a pulse.
- Latency, when `raw_i[i]` changes before edge 1 and then holds:
  - `sync[i]` updates at edge `SYNC_STAGES`.
  - `stable_o[i]` and the pulse update at edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
  - Default parameters give 2 + 250000 cycles.
- The pulse deasserts at the following edge.
- `stable_o` changes at most once per `DEBOUNCE_CYCLES` cycles per bit.

## Test plan

Bench parameters: `WIDTH=4`, `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`, `RESET_VAL=0`.

- **Reset values:** hold `arst_i` high with `raw_i=4'hF`. Required: `stable_o=0`, `rise_o=0`, `fall_o=0`, `any_change_o=0`. Release reset and keep `raw_i=4'hF`. Required: `stable_o=4'hF` after exactly 6 edges, with `rise_o=4'hF` and `any_change_o=1` for one cycle.
- **Clean edge:** from steady 0, set `raw_i[0]=1` before edge 1. Required: `stable_o[0]=1` after edge 6, `rise_o[0]` high in cycle 6 only. Then set `raw_i[0]=0`. Required: `fall_o[0]` pulses 6 edges later.
- **Glitch rejection:** pulse `raw_i[1]` high for 3 cycles, then low. Required: `stable_o[1]` stays 0 and no pulse on any output. Then bounce `raw_i[1]` 1,0,1,0,1 over 5 cycles, then hold 1. Required: acceptance 6 edges after the final rising change.
- **Independent bits:** raise `raw_i[2]` and `raw_i[3]` on the same edge. Required: `rise_o=4'b1100` in one cycle. Raise `raw_i[2]` 2 cycles before `raw_i[3]`. Required: two separate single-bit pulses 2 cycles apart.
- **Reset mid-operation:** raise `raw_i[0]` and assert `arst_i` 4 edges later, before acceptance. Required: `cnt`, `stable_o` and the pulses cleared immediately. After release with `raw_i[0]` still 1, required: a fresh full 6-edge latency, with no early acceptance.
